// File: rtl/word_unpack_tx_if.sv
// BRAM read-port / UART-trigger bundle for word_unpack_tx.
// master = the unpacker, slave = the controller, BRAM and UART side.
interface word_unpack_tx_if #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 25250
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  start_in;
  logic                  abort_in;
  logic [ADDR_W-1:0]     word_count_in;
  logic [ADDR_W-1:0]     addr_out;
  logic [WORD_WIDTH-1:0] data_in;
  logic [7:0]            byte_out;
  logic                  byte_valid_out;
  logic                  tx_busy_in;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    input  start_in, abort_in, word_count_in, data_in, tx_busy_in,
    output addr_out, byte_out, byte_valid_out, busy_out, done_out
  );

  modport slave (
    output start_in, abort_in, word_count_in, data_in, tx_busy_in,
    input  addr_out, byte_out, byte_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/word_unpack_tx.sv
// Streams N BRAM words to a UART transmitter, MSB byte first, one byte per trigger/busy handshake.
// Optional UNPACK_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module word_unpack_tx #(
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH        = 25250,
  parameter int READ_LATENCY = 2      // must be >= 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  word_unpack_tx_if.master bus
);
  localparam int NBYTES = WORD_WIDTH / 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE
`ifdef UNPACK_CHECKSUM_EN
    , S_SEND_CSUM
`endif
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [LAT_W-1:0]      r_lat;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [BIDX_W-1:0]     r_bidx;
  logic [ADDR_W:0]       r_widx;
  logic [ADDR_W:0]       r_n;
  logic [7:0]            r_byte;
  logic                  r_bvalid;
  logic                  r_busy;
  logic                  r_done;
`ifdef UNPACK_CHECKSUM_EN
  logic [7:0]            r_csum;
  logic                  r_csum_ph;
`endif

  logic [ADDR_W:0] w_cnt;
  logic [ADDR_W:0] w_n;
  logic            w_last_byte;
  logic            w_last_word;

  // Counter is one bit wider than the address so N == DEPTH is representable.
  assign w_cnt       = {1'b0, bus.word_count_in};
  assign w_n         = (w_cnt > N_MAX) ? N_MAX : w_cnt;
  assign w_last_byte = (r_bidx == BIDX_W'(NBYTES - 1));
  assign w_last_word = ((r_widx + (ADDR_W+1)'(1)) >= r_n);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_lat     <= '0;
      r_shift   <= '0;
      r_bidx    <= '0;
      r_widx    <= '0;
      r_n       <= '0;
      r_byte    <= '0;
      r_bvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UNPACK_CHECKSUM_EN
      r_csum    <= '0;
      r_csum_ph <= 1'b0;
`endif
    end else begin
      r_bvalid <= 1'b0;
      r_done   <= 1'b0;
      if (bus.abort_in && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_addr  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start_in && !bus.abort_in) begin
              r_n    <= w_n;
              r_widx <= '0;
              r_bidx <= '0;
              r_lat  <= '0;
              r_addr <= '0;
              r_busy <= 1'b1;
`ifdef UNPACK_CHECKSUM_EN
              r_csum    <= '0;
              r_csum_ph <= 1'b0;
              r_state   <= (w_n == '0) ? S_SEND_CSUM : S_FETCH;
`else
              if (w_n == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_FETCH;
              end
`endif
            end
          end
          // Address is held while the BRAM pipeline fills.
          S_FETCH: begin
            if (r_lat == LAT_W'(READ_LATENCY - 1)) r_state <= S_LOAD;
            else                                   r_lat   <= r_lat + LAT_W'(1);
          end
          S_LOAD: begin
            r_shift <= bus.data_in;
            r_bidx  <= '0;
            r_state <= S_SEND;
          end
          S_SEND: begin
            r_byte   <= r_shift[WORD_WIDTH-1 -: 8];
            r_bvalid <= 1'b1;
            r_shift  <= r_shift << 8;
`ifdef UNPACK_CHECKSUM_EN
            r_csum   <= r_csum ^ r_shift[WORD_WIDTH-1 -: 8];
`endif
            r_state  <= S_WAIT_HI;
          end
          S_WAIT_HI: if (bus.tx_busy_in) r_state <= S_WAIT_LO;
          S_WAIT_LO: begin
            if (!bus.tx_busy_in) begin
`ifdef UNPACK_CHECKSUM_EN
              if (r_csum_ph) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else
`endif
              if (!w_last_byte) begin
                r_bidx  <= r_bidx + BIDX_W'(1);
                r_state <= S_SEND;
              end else if (!w_last_word) begin
                r_widx  <= r_widx + (ADDR_W+1)'(1);
                r_addr  <= r_widx[ADDR_W-1:0] + ADDR_W'(1);
                r_lat   <= '0;
                r_state <= S_FETCH;
              end else begin
`ifdef UNPACK_CHECKSUM_EN
                r_state <= S_SEND_CSUM;
`else
                r_state <= S_DONE;
                r_done  <= 1'b1;
`endif
              end
            end
          end
`ifdef UNPACK_CHECKSUM_EN
          S_SEND_CSUM: begin
            r_byte    <= r_csum;
            r_bvalid  <= 1'b1;
            r_csum_ph <= 1'b1;
            r_state   <= S_WAIT_HI;
          end
`endif
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.addr_out       = r_addr;
  assign bus.byte_out       = r_byte;
  assign bus.byte_valid_out = r_bvalid;
  assign bus.busy_out       = r_busy;
  assign bus.done_out       = r_done;
endmodule

// File: tb/tb_word_unpack_tx.sv
// Directed bench: BRAM + UART models, expected bytes queued at start and checked on each trigger.
module tb_word_unpack_tx;
  localparam int WW    = 32;
  localparam int DEPTH = 10;
  localparam int RL    = 2;
  localparam int AW    = $clog2(DEPTH);
`ifdef UNPACK_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  word_unpack_tx_if #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) bus ();

  word_unpack_tx #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus.master)
  );

  // BRAM read port, two-cycle latency (address reg + output reg)
  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] a_q;
  always @(posedge clk) begin
    a_q         <= bus.addr_out;
    bus.data_in <= mem[a_q];
  end

  // UART: after a trigger, u_dly idle cycles then u_len busy cycles
  int   u_dly = 0;
  int   u_len = 4;
  int   u_cnt = 0;
  logic u_act = 1'b0;
  always @(posedge clk) begin
    if (!u_act && bus.byte_valid_out) begin
      u_act <= 1'b1;
      u_cnt <= u_dly + u_len;
    end else if (u_act) begin
      if (u_cnt == 0) u_act <= 1'b0;
      else            u_cnt <= u_cnt - 1;
    end
  end
  assign bus.tx_busy_in = u_act && (u_cnt < u_len);

  int checks = 0;
  int failures = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_seq[$];
  logic [7:0]    csum;
  int trig_cnt, done_cnt, done_cyc, fall_cyc;
  logic prev_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    for (int i = WW/8 - 1; i >= 0; i--) begin
      exp_q.push_back(w[i*8 +: 8]);
      csum = csum ^ w[i*8 +: 8];
    end
  endtask

  task automatic push_csum();
`ifdef UNPACK_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
  endtask

  task automatic sample(input int c);
    if (prev_busy && !bus.tx_busy_in) fall_cyc = c;
    prev_busy = bus.tx_busy_in;
    if (bus.busy_out && (addr_seq.size() == 0 || addr_seq[$] != bus.addr_out))
      addr_seq.push_back(bus.addr_out);
    if (bus.byte_valid_out) begin
      trig_cnt++;
      chk("no_dup_trigger", u_act, 0);
      chk("exp_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("byte", bus.byte_out, exp_q.pop_front());
    end
    if (bus.done_out) done_cnt++;
  endtask

  task automatic begin_xfer(input int n);
    trig_cnt = 0; done_cnt = 0; done_cyc = -1; fall_cyc = -1;
    addr_seq.delete();
    prev_busy = bus.tx_busy_in;
    @(negedge clk);
    bus.word_count_in = AW'(n);
    bus.start_in = 1'b1;
  endtask

  task automatic run_xfer(input int n, input int hold, input int max_cyc);
    begin_xfer(n);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      bus.start_in = (c < hold);
      sample(c);
      if (bus.done_out) begin
        done_cyc = c;
        break;
      end
    end
    bus.start_in = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.done_out, 0);
    chk("idle_after_done", bus.busy_out, 0);
    chk("exp_drained", exp_q.size(), 0);
  endtask

  task automatic wait_uart_idle();
    for (int c = 0; c < 200 && u_act; c++) @(negedge clk);
    chk("uart_idle", u_act, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_in = 1'b0;
    bus.abort_in = 1'b0;
    bus.word_count_in = '0;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr",  bus.addr_out, 0);
    chk("rst_byte",  bus.byte_out, 0);
    chk("rst_valid", bus.byte_valid_out, 0);
    chk("rst_busy",  bus.busy_out, 0);
    chk("rst_done",  bus.done_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word, long busy
    u_len = 20; u_dly = 0;
    mem[0] = 32'hDEADBEEF;
    csum = '0; push_word(32'hDEADBEEF); push_csum();
    run_xfer(1, 0, 500);
    chk("single_trig", trig_cnt, 4 + CS);
    chk("done_after_fall", done_cyc - fall_cyc, 1);
    chk("single_done_cnt", done_cnt, 1);

    // three words, latency alignment
    u_len = 4;
    for (int k = 0; k < DEPTH; k++) mem[k] = k * 32'h01010101;
    csum = '0;
    for (int k = 0; k < 3; k++) push_word(k * 32'h01010101);
    push_csum();
    run_xfer(3, 0, 1000);
    chk("multi_trig", trig_cnt, 12 + CS);
    chk("multi_naddr", addr_seq.size(), 3);
    for (int k = 0; k < 3 && k < addr_seq.size(); k++) chk("multi_addr", addr_seq[k], k);

    // N = 0
    csum = '0; push_csum();
    run_xfer(0, 0, 200);
    chk("n0_trig", trig_cnt, CS);
`ifndef UNPACK_CHECKSUM_EN
    chk("n0_done_lat", done_cyc, 0);
`endif

    // count above DEPTH clamps
    u_len = 2;
    csum = '0;
    for (int k = 0; k < DEPTH; k++) push_word(k * 32'h01010101);
    push_csum();
    run_xfer(DEPTH + 5, 0, 3000);
    chk("clamp_trig", trig_cnt, 4*DEPTH + CS);
    chk("clamp_naddr", addr_seq.size(), DEPTH);
    if (addr_seq.size() > 0) chk("clamp_last_addr", addr_seq[$], DEPTH - 1);

    // slow busy rise, start held high mid-transfer
    u_dly = 3; u_len = 6;
    mem[0] = 32'hA5C30F96;
    csum = '0; push_word(32'hA5C30F96); push_csum();
    run_xfer(1, 30, 1000);
    chk("slow_trig", trig_cnt, 4 + CS);
    chk("slow_done_cnt", done_cnt, 1);

    // abort during word 1 byte 2
    u_dly = 0; u_len = 4;
    mem[0] = 32'h11223344; mem[1] = 32'h55667788; mem[2] = 32'h99AABBCC;
    csum = '0; push_word(32'h11223344);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    begin_xfer(3);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      sample(c);
      if (trig_cnt == 7) begin
        bus.abort_in = 1'b1;
        break;
      end
    end
    chk("abort_reached", trig_cnt, 7);
    @(negedge clk);
    bus.abort_in = 1'b0;
    chk("abort_busy",  bus.busy_out, 0);
    chk("abort_addr",  bus.addr_out, 0);
    chk("abort_valid", bus.byte_valid_out, 0);
    trig_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sample(c);
    end
    chk("abort_no_trig", trig_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_drained", exp_q.size(), 0);
    wait_uart_idle();

    // async reset mid-transfer, then restart from address 0
    mem[0] = 32'hCAFEF00D; mem[1] = 32'h0BADC0DE;
    csum = '0; push_word(32'hCAFEF00D); push_word(32'h0BADC0DE);
    begin_xfer(2);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      sample(c);
      if (trig_cnt == 2) break;
    end
    chk("rst_mid_reached", trig_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr",  bus.addr_out, 0);
    chk("arst_byte",  bus.byte_out, 0);
    chk("arst_valid", bus.byte_valid_out, 0);
    chk("arst_busy",  bus.busy_out, 0);
    chk("arst_done",  bus.done_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    wait_uart_idle();
    csum = '0; push_word(32'hCAFEF00D); push_csum();
    run_xfer(1, 0, 500);
    chk("restart_trig", trig_cnt, 4 + CS);
    if (addr_seq.size() > 0) chk("restart_addr0", addr_seq[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/word_unpack_tx.md
Name: word_unpack_tx

Overview:
- Read-side counterpart of the 4-byte packer. Fetches a run of stored words from the audio BRAM read port and splits each one into bytes, most significant byte first.
- Feeds the bytes one at a time into uart_transmit using its trigger/busy handshake.
- Replaces the ad-hoc idx/total_count byte sequencer in top level. Guarantees that every byte is sent exactly once, with correct BRAM read-latency alignment.

Parameters:
- WORD_WIDTH, 32, stored word width; must be a multiple of 8. NBYTES = WORD_WIDTH/8.
- DEPTH, 25250, BRAM depth in words. ADDR_W = $clog2(DEPTH).
- READ_LATENCY, 2, cycles from addr_out change to valid data_in (2 = HIGH_PERFORMANCE BRAM).

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous, active-low reset
- start_in  input  1  one-cycle pulse that begins a transfer; ignored unless idle
- abort_in  input  1  synchronous abort; returns the block to idle
- word_count_in  input  ADDR_W  number of words to send; sampled on start_in
- addr_out  output  ADDR_W  BRAM read-port address
- data_in  input  WORD_WIDTH  BRAM read data
- byte_out  output  8  byte presented to the UART transmitter
- byte_valid_out  output  1  one-cycle trigger to the UART transmitter
- tx_busy_in  input  1  UART transmitter busy
- busy_out  output  1  high whenever the block is not idle
- done_out  output  1  one-cycle pulse when a transfer completes normally

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE. addr_out, byte_out, byte_valid_out, busy_out and done_out are all 0. Word index and byte index are 0.
- States: IDLE, FETCH, LOAD, SEND, WAIT_HI, WAIT_LO, DONE.
- IDLE, start_in=1:
  - Latch N = min(word_count_in, DEPTH).
  - N=0 -> DONE.
  - Otherwise addr_out<=0, latency counter<=0, -> FETCH.
- FETCH: hold addr_out and count cycles. After READ_LATENCY cycles -> LOAD.
- LOAD: capture data_in into the shift register, byte index<=0, -> SEND.
- SEND:
  - byte_out <= shift[WORD_WIDTH-1 -: 8]; byte_valid_out=1 for exactly one cycle.
  - Shift the register left by 8, -> WAIT_HI.
- WAIT_HI: stay until tx_busy_in=1 is sampled, then -> WAIT_LO. A trigger is never re-issued while waiting.
- WAIT_LO: stay until tx_busy_in=0.
  - If byte index < NBYTES-1: index++, -> SEND.
  - Else, if word index < N-1: word++, addr_out<=word+1, -> FETCH.
  - Else -> DONE.
- Address prefetch: the next fetch is issued only after the previous word is fully captured. addr_out is stable throughout FETCH.
- DONE: done_out=1 for one cycle, then -> IDLE.
- busy_out = (state != IDLE), registered.
- byte_out holds its last value between triggers.
- abort_in=1 in any non-IDLE state:
  - Next state IDLE, byte_valid_out=0, no done_out, addr_out<=0.
  - A byte already accepted by the UART finishes on the wire; no new trigger is issued.
- abort_in wins over start_in in the same cycle.
- start_in while busy_out=1 is ignored.
- Byte throughput per word: NBYTES UART frames, plus READ_LATENCY+2 cycles of overhead.
- Width rules:
  - Word counter is ADDR_W+1 bits, so N=DEPTH terminates correctly.
  - addr_out never exceeds DEPTH-1 and never wraps.

Optional Feature:
- Macro UNPACK_CHECKSUM_EN.
- Defined:
  - Maintain an 8-bit running XOR of all transmitted data bytes; it is cleared on start_in.
  - After the last data byte's WAIT_LO, add a state SEND_CSUM that sends the XOR byte with the same SEND/WAIT_HI/WAIT_LO handshake, then -> DONE.
  - N=0 sends a single 0x00 checksum byte.
- Not defined: no checksum register or state. The byte stream is exactly 4·N bytes (for WORD_WIDTH=32).

Test Plan:
- Single word: BRAM[0]=0xDEADBEEF, N=1, UART model busy for 20 cycles after each trigger -> bytes 0xDE,0xAD,0xBE,0xEF in order, 4 triggers, done_out one cycle after the last busy fall.
- Multi-word latency check: BRAM[k]=k·0x01010101, N=3, READ_LATENCY=2 -> 12 bytes 00,00,00,00,01,01,01,01,02,02,02,02; addr_out steps 0,1,2, each address held ≥2 cycles before capture.
- Zero and ceiling: N=0 -> done_out 1 cycle after start_in, no byte_valid_out. N=DEPTH+5 clamps to DEPTH -> last addr_out=DEPTH-1, no wrap.
- Slow busy and abort:
  - tx_busy_in delayed 3 cycles after trigger -> no duplicate trigger.
  - abort_in during word 1, byte 2 -> idle next cycle, busy_out=0, no done_out, no further triggers.
  - start_in held high during a transfer -> ignored.
- Async reset mid-transfer: rst_in low between clock edges -> all outputs 0 immediately. A restart after release begins at address 0.
- With UNPACK_CHECKSUM_EN: BRAM[0]=0x12345678, N=1 -> bytes 12,34,56,78 then 0x08; done_out after the fifth byte.
